// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver with double-buffered display data
//
// Scans NUM_DIGITS digits over a shared segment bus and a one-hot select bus.
// A refresh divider holds each digit for REFRESH_DIV cycles. New data is
// captured into a pending buffer by load_i and only moves into the active
// buffer at a frame boundary, so a frame never mixes old and new data.
//
// Optional build macro: LEADING_ZERO_BLANK_EN (auto-blank leading zero digits).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   digits_i   hex nibbles, digit k = [4k+3:4k]
//   dp_i       decimal point request per digit
//   blank_i    force digit dark per digit
//   load_i     capture digits_i/dp_i/blank_i into the pending buffer
//   seg_o      segments, bit6=A .. bit0=G
//   dp_o       decimal point of the selected digit
//   sel_o      one-hot digit select
//   frame_o    pulse on the first output cycle of each frame
//   pending_o  pending buffer holds uncommitted data
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   sel_o,
  output logic                    frame_o,
  output logic                    pending_o
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic INV = (ACTIVE_LOW != 0);

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E;
      4'h1: hex7 = 7'h30;
      4'h2: hex7 = 7'h6D;
      4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;
      4'h5: hex7 = 7'h5B;
      4'h6: hex7 = 7'h5F;
      4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h7B;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;
      4'hD: hex7 = 7'h3D;
      4'hE: hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] act_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
  logic                    pending;
  logic                    new_frame;

  logic                    tick;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  assign tick     = (cnt == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Leading-zero mask: walk down from the top digit while digits stay zero
  // with no decimal point. Digit 0 is never part of the walk.
  always_comb begin
    lz_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic run;
      run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
        run = run && (act_digits[4*k +: 4] == 4'h0) && !act_dp[k];
        lz_blank[k] = run;
      end
    end
`endif
  end

  always_comb begin
    eff_blank    = act_blank | lz_blank;
    sel_nxt      = '0;
    sel_nxt[idx] = 1'b1;
    seg_nxt      = eff_blank[idx] ? 7'h00 : hex7(act_digits[4*idx +: 4]);
    dp_nxt       = act_dp[idx] & ~eff_blank[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '1;
      pending     <= 1'b0;
      new_frame   <= 1'b1;
      seg_o       <= {7{INV}};
      dp_o        <= INV;
      sel_o       <= {NUM_DIGITS{INV}};
      frame_o     <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // Commit uses the pending state from before this edge; a load on the
      // boundary edge itself stays pending for the next frame.
      if (boundary && pending) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blank  <= pend_blank;
      end
      if (load_i) begin
        pend_digits <= digits_i;
        pend_dp     <= dp_i;
        pend_blank  <= blank_i;
        pending     <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end

      // new_frame marks that idx has just returned to 0; the output stage
      // turns it into frame_o alongside digit 0's select.
      new_frame <= boundary;
      frame_o   <= new_frame;
      seg_o     <= seg_nxt ^ {7{INV}};
      dp_o      <= dp_nxt ^ INV;
      sel_o     <= sel_nxt ^ {NUM_DIGITS{INV}};
    end
  end

  assign pending_o = pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_i;
  logic [3:0]  dp_i;
  logic [3:0]  blank_i;
  logic        load_i;

  logic [6:0]  seg_o, seg_a;
  logic        dp_o, dp_a;
  logic [3:0]  sel_o, sel_a;
  logic        frame_o, frame_a;
  logic        pending_o, pending_a;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
    .load_i(load_i), .seg_o(seg_o), .dp_o(dp_o), .sel_o(sel_o),
    .frame_o(frame_o), .pending_o(pending_o)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst_n(rst_n), .digits_i(digits_i), .dp_i(dp_i), .blank_i(blank_i),
    .load_i(load_i), .seg_o(seg_a), .dp_o(dp_a), .sel_o(sel_a),
    .frame_o(frame_a), .pending_o(pending_a)
  );

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
  } exp_t;

  exp_t sb[$];

  logic [6:0] dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Queue the 16 output cycles expected for one frame of the given active data.
  task automatic push_frame(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
    logic [3:0] eb;
    exp_t e;
    eb = bl;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic run;
      run = 1'b1;
      for (int k = 3; k >= 1; k--) begin
        run = run && (dg[4*k +: 4] == 4'h0) && !dpv[k];
        if (run) eb[k] = 1'b1;
      end
    end
`endif
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        e.sel = 4'b0001 << d;
        e.seg = eb[d] ? 7'h00 : dec_tab[dg[4*d +: 4]];
        e.dp  = dpv[d] & ~eb[d];
        e.fr  = (d == 0) && (c == 0);
        sb.push_back(e);
      end
    end
  endtask

  // Wait for a frame start, then compare 16 output cycles against the queue,
  // optionally driving up to two loads at given output cycles.
  task automatic run_frame(input int lc1, input logic [15:0] d1, input logic [3:0] p1,
                           input logic [3:0] b1, input int lc2, input logic [15:0] d2,
                           input int pend0);
    int   n;
    exp_t e;
    n = 0;
    while (frame_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL frame_start_timeout frame_o=%b required=1", frame_o);
    end
    for (int i = 0; i < 16; i++) begin
      e = sb.pop_front();
      checks++;
      if ({sel_o, seg_o, dp_o, frame_o} !== {e.sel, e.seg, e.dp, e.fr}) begin
        failures++;
        $display("FAIL scan_cycle%0d sel=%b seg=%h dp=%b frame=%b required sel=%b seg=%h dp=%b frame=%b",
                 i, sel_o, seg_o, dp_o, frame_o, e.sel, e.seg, e.dp, e.fr);
      end
      checks++;
      if ({sel_a, seg_a, dp_a, frame_a} !== {~e.sel, ~e.seg, ~e.dp, e.fr}) begin
        failures++;
        $display("FAIL active_low_cycle%0d sel=%b seg=%h dp=%b frame=%b required sel=%b seg=%h dp=%b frame=%b",
                 i, sel_a, seg_a, dp_a, frame_a, ~e.sel, ~e.seg, ~e.dp, e.fr);
      end
      if (i == 0 && pend0 >= 0) begin
        checks++;
        if (pending_o !== pend0[0]) begin
          failures++;
          $display("FAIL pending_at_frame_start pending=%b required=%b", pending_o, pend0[0]);
        end
      end
      if (lc1 >= 0 && i == lc1 + 1) begin
        checks++;
        if (pending_o !== 1'b1 || pending_a !== 1'b1) begin
          failures++;
          $display("FAIL pending_after_load pending=%b/%b required=1", pending_o, pending_a);
        end
      end
      load_i = 1'b0;
      if (i == lc1) begin
        load_i = 1'b1; digits_i = d1; dp_i = p1; blank_i = b1;
      end
      if (i == lc2) begin
        load_i = 1'b1; digits_i = d2;
      end
      @(negedge clk);
    end
    load_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({sel_o, seg_o, dp_o, frame_o, pending_o} !== {4'h0, 7'h00, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s sel=%b seg=%h dp=%b frame=%b pending=%b required all zero",
               name, sel_o, seg_o, dp_o, frame_o, pending_o);
    end
    checks++;
    if ({sel_a, seg_a, dp_a, frame_a, pending_a} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s_active_low sel=%b seg=%h dp=%b frame=%b pending=%b required sel=1111 seg=7f dp=1 frame=0 pending=0",
               name, sel_a, seg_a, dp_a, frame_a, pending_a);
    end
  endtask

  task automatic check_first_cycle(input string name);
    checks++;
    if ({frame_o, sel_o, seg_o} !== {1'b1, 4'b0001, 7'h00}) begin
      failures++;
      $display("FAIL %s frame=%b sel=%b seg=%h required frame=1 sel=0001 seg=00",
               name, frame_o, sel_o, seg_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_i = 1'b0; digits_i = '0; dp_i = '0; blank_i = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_first_cycle("first_cycle_after_reset");
  endtask

  task automatic test_idle();
    push_frame(16'h0000, 4'h0, 4'hF);
    push_frame(16'h0000, 4'h0, 4'hF);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
  endtask

  task automatic test_load_commit();
    push_frame(16'h0000, 4'h0, 4'hF);
    run_frame(5, 16'h3A0F, 4'b0100, 4'h0, -1, 16'h0, 0);
    push_frame(16'h3A0F, 4'b0100, 4'h0);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
  endtask

  task automatic test_last_load_wins();
    push_frame(16'h3A0F, 4'b0100, 4'h0);
    run_frame(2, 16'h1111, 4'h0, 4'h0, 8, 16'h2222, 0);
    push_frame(16'h2222, 4'h0, 4'h0);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
  endtask

  task automatic test_boundary_load();
    push_frame(16'h2222, 4'h0, 4'h0);
    run_frame(14, 16'h4444, 4'h0, 4'h0, -1, 16'h0, 0);
    push_frame(16'h2222, 4'h0, 4'h0);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 1);
    push_frame(16'h4444, 4'h0, 4'h0);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
  endtask

  task automatic test_active_low();
    push_frame(16'h4444, 4'h0, 4'h0);
    run_frame(3, 16'h8888, 4'h0, 4'b0010, -1, 16'h0, 0);
    push_frame(16'h8888, 4'h0, 4'b0010);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
  endtask

  task automatic test_reset_midframe();
    int n;
    n = 0;
    while (frame_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    load_i = 1'b1; digits_i = 16'h0050; dp_i = 4'h0; blank_i = 4'h0;
    @(negedge clk);
    load_i = 1'b0;
    checks++;
    if (pending_o !== 1'b1) begin
      failures++;
      $display("FAIL midframe_pending pending=%b required=1", pending_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    check_reset_vals("midframe_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_first_cycle("first_cycle_after_midframe_reset");
    push_frame(16'h0000, 4'h0, 4'hF);
    run_frame(4, 16'h0050, 4'h0, 4'h0, -1, 16'h0, 0);
    push_frame(16'h0050, 4'h0, 4'h0);
    run_frame(-1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 0);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_commit();
    test_last_load_wins();
    test_boundary_load();
    test_active_low();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
